// File: rtl/shift_sched.sv
// shifter: rotate by sh, keep a 32-maskbits window (low for right, high for left), optional sign fill.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller holds inputs for as long as it needs the result.
module shifter (
    input  logic [31:0] op,
    input  logic [4:0]  sh,
    input  logic [4:0]  maskbits,
    input  logic        left,
    input  logic        sx,
    output logic [31:0] out
);
    logic [63:0] dbl;
    logic [31:0] rot;
    logic [31:0] keep;
    logic        top;

    // Rotate through a doubled word, then clear or sign-fill the bits outside the kept window
    always_comb begin
        if (left) begin
            dbl  = {op, op} << sh;
            rot  = dbl[63:32];
            keep = 32'hFFFF_FFFF << maskbits;
            top  = rot[31];
        end else begin
            dbl  = {op, op} >> sh;
            rot  = dbl[31:0];
            keep = 32'hFFFF_FFFF >> maskbits;
            top  = rot[5'd31 - maskbits];
        end
        out = (rot & keep) | ((sx && top) ? ~keep : 32'h0);
    end
endmodule

// shift_sched: round-robin two-port sequencer owning the single shifter; single-pass ops or two-pass bitfield insert.
// Latency: response valid 1 cycle after accept (single pass, zero-width insert) or 2 cycles (insert).
// Backpressure: one op in flight; req_ready stays low until the addressed port takes the held response.
module shift_sched (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_kind,
    input  logic [1:0][31:0] req_a,
    input  logic [1:0][31:0] req_b,
    input  logic [1:0][4:0]  req_sh,
    input  logic [1:0][4:0]  req_maskbits,
    input  logic [1:0]       req_left,
    input  logic [1:0]       req_sx,
    input  logic [1:0][5:0]  req_w,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [31:0]      resp_data
);
    typedef enum logic [1:0] {IDLE, PASS2, RESP} state_t;

    state_t      state;
    logic        last;
    logic        id;
    logic [31:0] res;
    logic [31:0] b_q;
    logic [4:0]  pos_q;
    logic [5:0]  w_q;

    logic [1:0]  grant;
    logic        gid;
    logic [5:0]  room;
    logic [5:0]  w_clamp;
    logic [4:0]  p2_mb;
    logic [31:0] ins_m;

    logic [31:0] sh_op;
    logic [4:0]  sh_amt;
    logic [4:0]  sh_mb;
    logic        sh_left;
    logic        sh_sx;
    logic [31:0] sh_out;

    // Lone requester wins; on a tie the port not served last wins
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

    assign gid       = grant[1];
    assign req_ready = ((state == IDLE) && rst_n) ? grant : 2'b00;
    assign resp_data = res;

    // Field width cannot run past bit 31
    assign room    = 6'd32 - {1'b0, req_sh[gid]};
    assign w_clamp = (req_w[gid] > room) ? room : req_w[gid];

    // 32-pos-w is always 0..31 here, so 5-bit wraparound arithmetic yields it exactly
    assign p2_mb = 5'd0 - pos_q - w_q[4:0];
    // 33-bit so that a full 32-bit field produces an all-ones mask
    assign ins_m = 32'(((33'd1 << w_q) - 33'd1) << pos_q);

    // Shifter input select: granted request in IDLE (insert pass 1 forces a<<pos), latched result in PASS2
    always_comb begin
        sh_op   = req_a[gid];
        sh_amt  = req_sh[gid];
        sh_mb   = req_maskbits[gid];
        sh_left = req_left[gid];
        sh_sx   = req_sx[gid];
        if (state == PASS2) begin
            sh_op   = res;
            sh_amt  = 5'd0;
            sh_mb   = p2_mb;
            sh_left = 1'b0;
            sh_sx   = 1'b0;
        end else if (req_kind[gid]) begin
            sh_mb   = req_sh[gid];
            sh_left = 1'b1;
            sh_sx   = 1'b0;
        end
    end

    shifter u_shifter (
        .op       (sh_op),
        .sh       (sh_amt),
        .maskbits (sh_mb),
        .left     (sh_left),
        .sx       (sh_sx),
        .out      (sh_out)
    );

    // Sequencer: accept, optional second insert pass, hold response until the owner takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last       <= 1'b1;
            id         <= 1'b0;
            res        <= 32'h0;
            b_q        <= 32'h0;
            pos_q      <= 5'd0;
            w_q        <= 6'd0;
            resp_valid <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        id   <= gid;
                        last <= gid;
                        if (!req_kind[gid]) begin
                            res        <= sh_out;
                            resp_valid <= grant;
                            state      <= RESP;
                        end else if (w_clamp == 6'd0) begin
                            res        <= req_b[gid];
                            resp_valid <= grant;
                            state      <= RESP;
                        end else begin
                            res   <= sh_out;
                            b_q   <= req_b[gid];
                            pos_q <= req_sh[gid];
                            w_q   <= w_clamp;
                            state <= PASS2;
                        end
                    end
                end
                PASS2: begin
                    res        <= (b_q & ~ins_m) | sh_out;
                    resp_valid <= id ? 2'b10 : 2'b01;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready[id]) begin
                        resp_valid <= 2'b00;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 2'b00;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_sched.sv
module tb_shift_sched;
    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_kind;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    logic [1:0][4:0]  req_sh;
    logic [1:0][4:0]  req_maskbits;
    logic [1:0]       req_left;
    logic [1:0]       req_sx;
    logic [1:0][5:0]  req_w;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [31:0]      resp_data;

    int          checks = 0;
    int          failures = 0;
    int          last_m;
    logic [1:0]  obs_grant;
    logic [31:0] obs_data;
    int          gp;

    shift_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_kind     (req_kind),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_sh       (req_sh),
        .req_maskbits (req_maskbits),
        .req_left     (req_left),
        .req_sx       (req_sx),
        .req_w        (req_w),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int p);
        return (p != 0) ? 2'b10 : 2'b01;
    endfunction

    // Bitwise reference of the shifter: rotate, then fill everything outside the kept window
    function automatic logic [31:0] m_shift(input logic [31:0] op, input int sh, input int mb,
                                            input bit left, input bit sx);
        logic [31:0] r;
        int lo, hi;
        logic fill;
        for (int i = 0; i < 32; i++)
            r[i] = left ? op[(i - sh + 32) % 32] : op[(i + sh) % 32];
        if (left) begin lo = mb; hi = 31; end
        else      begin lo = 0;  hi = 31 - mb; end
        fill = sx && r[hi];
        for (int i = 0; i < 32; i++)
            if (i < lo || i > hi) r[i] = fill;
        return r;
    endfunction

    function automatic int m_wc(input int pos, input int w);
        return (w > 32 - pos) ? 32 - pos : w;
    endfunction

    // Bitfield insert: low wc bits of a replace b[pos+wc-1:pos]
    function automatic logic [31:0] m_insert(input logic [31:0] a, input logic [31:0] b,
                                             input int pos, input int w);
        logic [31:0] r;
        int wc;
        wc = m_wc(pos, w);
        r  = b;
        for (int i = 0; i < wc; i++) r[pos + i] = a[i];
        return r;
    endfunction

    function automatic logic [31:0] m_result(input int p);
        if (req_kind[p])
            return m_insert(req_a[p], req_b[p], int'(req_sh[p]), int'(req_w[p]));
        return m_shift(req_a[p], int'(req_sh[p]), int'(req_maskbits[p]), req_left[p], req_sx[p]);
    endfunction

    function automatic int m_latency(input int p);
        if (req_kind[p] && m_wc(int'(req_sh[p]), int'(req_w[p])) > 0) return 2;
        return 1;
    endfunction

    function automatic int m_grant(input logic [1:0] vld);
        if (vld == 2'b01) return 0;
        if (vld == 2'b10) return 1;
        return (last_m == 1) ? 0 : 1;
    endfunction

    task automatic randomize_port(input int p);
        req_kind[p]     = 1'($urandom_range(0, 1));
        req_a[p]        = $urandom;
        req_b[p]        = $urandom;
        req_sh[p]       = 5'($urandom_range(0, 31));
        req_maskbits[p] = 5'($urandom_range(0, 31));
        req_left[p]     = 1'($urandom_range(0, 1));
        req_sx[p]       = 1'($urandom_range(0, 1));
        req_w[p]        = 6'($urandom_range(0, 32));
    endtask

    task automatic set_single(input int p, input logic [31:0] a, input int sh, input int mb,
                              input bit left, input bit sx);
        randomize_port(p);
        req_kind[p]     = 1'b0;
        req_a[p]        = a;
        req_sh[p]       = 5'(sh);
        req_maskbits[p] = 5'(mb);
        req_left[p]     = left;
        req_sx[p]       = sx;
    endtask

    task automatic set_ins(input int p, input logic [31:0] a, input logic [31:0] b,
                           input int pos, input int w);
        randomize_port(p);
        req_kind[p] = 1'b1;
        req_a[p]    = a;
        req_b[p]    = b;
        req_sh[p]   = 5'(pos);
        req_w[p]    = 6'(w);
    endtask

    // One full transaction: grant, latency, held response, handshake
    task automatic do_op(input logic [1:0] vld, input int hold, output int g);
        logic [31:0] exp_d;
        int lat;
        @(negedge clk);
        req_valid = vld;
        g     = m_grant(vld);
        exp_d = m_result(g);
        lat   = m_latency(g);
        #1;
        obs_grant = req_ready;
        check("grant", 32'(req_ready), 32'(onehot(g)));
        last_m = g;
        @(posedge clk);
        #1;
        randomize_port(0);
        randomize_port(1);
        for (int c = 1; c < lat; c++) begin
            @(negedge clk);
            check("resp_early", 32'(resp_valid), 32'h0);
            check("ready_pass2", 32'(req_ready), 32'h0);
        end
        @(negedge clk);
        obs_data = resp_data;
        check("resp_valid", 32'(resp_valid), 32'(onehot(g)));
        check("resp_data", resp_data, exp_d);
        check("ready_busy", 32'(req_ready), 32'h0);
        resp_ready = onehot(1 - g);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            check("hold_valid", 32'(resp_valid), 32'(onehot(g)));
            check("hold_data", resp_data, exp_d);
            check("hold_ready", 32'(req_ready), 32'h0);
        end
        resp_ready = onehot(g) | 2'($urandom_range(0, 3));
        @(posedge clk);
        #1;
        resp_ready = 2'b00;
        req_valid  = 2'b00;
        check("resp_clear", 32'(resp_valid), 32'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        randomize_port(0);
        randomize_port(1);
        last_m     = 1;
        repeat (2) @(negedge clk);
        req_valid = 2'b11;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_data", resp_data, 32'h0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // Tie arbitration straight out of reset: 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            set_single(0, $urandom, $urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            set_single(1, $urandom, $urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            do_op(2'b11, 0, gp);
            check("arb_tie_seq", 32'(obs_grant), 32'(onehot(k % 2)));
        end
        for (int k = 0; k < 2; k++) begin
            set_single(1, $urandom, $urandom_range(0, 31), $urandom_range(0, 31), 1'b0, 1'b0);
            do_op(2'b10, 0, gp);
            check("arb_p1_alone", 32'(obs_grant), 32'h2);
        end
        set_single(0, $urandom, 3, 0, 1'b1, 1'b0);
        set_single(1, $urandom, 3, 0, 1'b1, 1'b0);
        do_op(2'b11, 0, gp);
        check("arb_tie_after_p1", 32'(obs_grant), 32'h1);

        // Directed values
        set_single(0, 32'h8000_0000, 4, 4, 1'b0, 1'b1);
        do_op(2'b01, 3, gp);
        check("single_sx", obs_data, 32'hF800_0000);
        set_ins(1, 32'h0000_ABCD, 32'hFFFF_FFFF, 8, 8);
        do_op(2'b10, 1, gp);
        check("ins_pos8_w8", obs_data, 32'hFFFF_CDFF);
        set_ins(1, 32'h0000_ABCD, 32'hFFFF_FFFF, 28, 8);
        do_op(2'b10, 0, gp);
        check("ins_clamp", obs_data, 32'hDFFF_FFFF);
        set_ins(0, $urandom, 32'h1234_5678, 5, 0);
        do_op(2'b01, 0, gp);
        check("ins_w0", obs_data, 32'h1234_5678);
        set_ins(0, 32'hCAFE_BABE, $urandom, 0, 32);
        do_op(2'b01, 0, gp);
        check("ins_w32", obs_data, 32'hCAFE_BABE);

        // Reset during PASS2 drops the op and restores the tie order
        @(negedge clk);
        set_ins(1, 32'h0000_00FF, 32'h0000_0000, 4, 8);
        req_valid = 2'b10;
        @(posedge clk);
        #1;
        check("pass2_no_resp", 32'(resp_valid), 32'h0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(resp_valid), 32'h0);
        check("rst_mid_data", resp_data, 32'h0);
        check("rst_mid_ready", 32'(req_ready), 32'h0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n  = 1'b1;
        last_m = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_stale_resp", 32'(resp_valid), 32'h0);
        end
        set_single(0, $urandom, 7, 2, 1'b0, 1'b0);
        set_single(1, $urandom, 7, 2, 1'b0, 1'b0);
        do_op(2'b11, 0, gp);
        check("rst_tie_p0", 32'(obs_grant), 32'h1);

        // Random mix against the reference model
        for (int k = 0; k < 40; k++) begin
            randomize_port(0);
            randomize_port(1);
            do_op(2'($urandom_range(1, 3)), $urandom_range(0, 2), gp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_sched.md
# shift_sched

Sequencer and two-port arbiter for the shared 32-bit `shifter` datapath. It accepts shift requests from two requesters: port 0 is execute and port 1 is load/store align. It grants one request at a time, round-robin. Each request is either a single-pass shifter operation or a two-pass bitfield insert. The registered result is returned on a per-requester valid/ready response channel. One operation is in flight at a time, and the block owns the only `shifter` instance.

## Interface
Parameters:
- none (width fixed at 32, requester count fixed at 2)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `req_valid` in 2: per-requester request valid
- `req_ready` out 2: per-requester accept; a request is accepted on a cycle where valid && ready
- `req_kind` in 2: per requester; 0 = single pass, 1 = insert
- `req_a` in 2x32: shifter operand (single pass) or insert source
- `req_b` in 2x32: insert destination; ignored for single pass
- `req_sh` in 2x5: shift amount (single) or insert position `pos`
- `req_maskbits` in 2x5: shifter mask count; single pass only
- `req_left`, `req_sx` in 2x1: shifter direction and sign-extend; single pass only
- `req_w` in 2x6: insert field width, 0..32
- `resp_valid` out 2: result valid for requester i
- `resp_ready` in 2: requester i consumes the result
- `resp_data` out 32: result, shared by both ports

## Operation
- Shifter function: rotate `op` right by `sh` (left: rotate left), keep the low 32-`maskbits` bits (left: the high 32-`maskbits` bits), and zero the rest. If `sx` is set and the top kept bit is 1, the cleared bits are set to 1.
- FSM states: IDLE, PASS2, RESP.
- IDLE:
  - `req_ready[i]` = grant[i].
  - Grant goes to the only valid requester. If both are valid, grant goes to the requester not served last. `last` resets to 1, so port 0 wins the first tie.
  - On accept, latch id, kind and operands, and update `last`.
  - Single pass: drive the shifter with the request fields, register `out` into `res`, go to RESP.
  - Insert: clamp `w` to min(w, 32-pos). Pass 1 drives op=a, sh=pos, maskbits=pos, left=1, sx=0, which gives a<<pos. Register the result into `res`, go to PASS2.
  - Insert with clamped w=0: register `b` into `res` and go to RESP. No PASS2.
- PASS2:
  - Drive op=`res`, sh=0, maskbits=32-pos-w (5-bit, always 0..31), left=0, sx=0. This gives the field bits limited to [pos+w-1:0].
  - `res` <= (b & ~M) | shifter_out, where M = ((1<<w)-1)<<pos is computed in 33-bit arithmetic, so w=32 gives all ones.
  - Go to RESP.
- RESP:
  - `resp_valid[id]`=1, `resp_data`=`res`. Both hold stable until `resp_ready[id]`.
  - On handshake, go to IDLE. A new request is not accepted in the same cycle.
- Both `req_ready` bits are 0 outside IDLE. At most one `req_ready` bit is set at any time.
- `resp_ready` of the non-addressed port is ignored.
- Shifter inputs are don't-care in RESP.

## Timing
- Reset values (async, immediate): state=IDLE, `last`=1, `req_ready`=0 during reset, `resp_valid`=0, `resp_data`=0, `res`=0.
- Single-pass latency: accept at edge T, `resp_valid` high from T+1.
- Insert latency: accept at T, `resp_valid` from T+2 (w=0 clamp: T+1).
- Throughput: with `resp_ready` held high, one op per 2 cycles (single) or 3 cycles (insert).
- `req_ready` is combinational from `req_valid` and state, with no dependency on `resp_ready`.
- Reset asserted mid-PASS2 or in RESP drops the operation with no response. The next grant after reset follows the reset `last`.
- Request fields need only be valid in the accept cycle.

## Test plan
- Single pass, port 0: a=0x80000000, sh=4, maskbits=4, left=0, sx=1 -> `resp_valid[0]` at T+1, `resp_data`=0xF8000000. Hold `resp_ready`=0 for 3 cycles -> data stable, `req_ready`=00.
- Insert, port 1: a=0xABCD, b=0xFFFFFFFF, pos=8, w=8 -> T+2, `resp_data`=0xFFFFCDFF. Repeat with pos=28, w=8 (clamped to 4) -> 0xDFFFFFFF.
- Insert edges: w=0 with b=0x12345678 -> 0x12345678 at T+1. pos=0, w=32, a=0xCAFEBABE -> 0xCAFEBABE at T+2.
- Arbitration: both ports valid continuously after reset, single-pass ops -> grants 0,1,0,1. Port 1 alone valid -> granted every time. Then both valid -> port 0 wins (last=1).
- Reset: assert `rst_n`=0 during PASS2 -> `resp_valid`=00 and `resp_data`=0 immediately. After release, the first tie goes to port 0 and no stale response appears.
